// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_slave
//  Description : AXI4-Lite single-beat memory responder. Serves read and
//                write transactions from an internal word-addressed SRAM with
//                per-byte write strobes. Addresses outside the mapped window
//                return SLVERR; reads of such addresses return zero data.
//
//  Ports       : clock, reset            - clock (rising edge), sync active-high reset
//                araddr/arvalid/arready  - read address channel
//                rdata/rresp/rvalid/rready - read data channel
//                awaddr/awvalid/awready  - write address channel
//                wdata/wstrb/wvalid/wready - write data channel
//                bresp/bvalid/bready     - write response channel
//
//  Parameters  : ADDR_BASE  - first byte address mapped to the SRAM
//                DEPTH_LOG2 - log2 of the SRAM word count
//                LATENCY    - wait cycles between acceptance and response (0..15)
//
//  Build macro : AXI_SRAM_RAND_DELAY_EN - when defined, each transaction's
//                delay comes from an 8-bit LFSR (0..7 cycles) instead of
//                LATENCY.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,

    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,

    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,

    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         c_depth  = 1 << DEPTH_LOG2;
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WAIT  = 2'd1,
        W_BRESP = 2'd2
    } wr_state_e;

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (addr >= ADDR_BASE) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
        return DEPTH_LOG2'((addr - ADDR_BASE) >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Per-transaction delay source
    // ------------------------------------------------------------------
    logic [3:0] txn_delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
    // Fibonacci LFSR, taps 8,6,5,4; free-running so read and write see
    // uncorrelated delays over time.
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign txn_delay = {1'b0, lfsr_q[2:0]};
`else
    localparam logic [3:0] c_latency = 4'(LATENCY);

    assign txn_delay = c_latency;
`endif

    // ------------------------------------------------------------------
    // Storage (not affected by reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [c_depth];

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0]           mem_data;
    logic [3:0]            mem_strb;

    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rd_addr_q,  rd_addr_d;
    logic [3:0]  rd_cnt_q,   rd_cnt_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [1:0]  rresp_q,    rresp_d;
    logic        rd_capture;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_capture = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;

        unique case (rd_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rd_addr_d = araddr;
                    if (txn_delay == 4'd0) begin
                        // Zero delay: sample the array on the accepting edge.
                        rd_capture = 1'b1;
                        rd_state_d = R_RESP;
                    end else begin
                        rd_cnt_d   = txn_delay - 4'd1;
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 4'd0) begin
                    rd_capture = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase

        // The array read here sees the pre-edge contents, so a write
        // committing to the same word on this edge is not observed.
        if (rd_capture) begin
            if (addr_in_range(rd_addr_d)) begin
                rdata_d = mem[word_index(rd_addr_d)];
                rresp_d = c_okay;
            end else begin
                rdata_d = 32'd0;
                rresp_d = c_slverr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= 32'd0;
            rd_cnt_q   <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= c_okay;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_got_q,   aw_got_d;
    logic        w_got_q,    w_got_d;
    logic [31:0] aw_addr_q,  aw_addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  wstrb_q,    wstrb_d;
    logic [3:0]  wr_cnt_q,   wr_cnt_d;
    logic [1:0]  bresp_q,    bresp_d;
    logic        wr_commit;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        aw_addr_d  = aw_addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_cnt_d   = wr_cnt_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;

        unique case (wr_state_q)
            W_IDLE: begin
                // Each ready line drops independently once its beat is held.
                awready = !aw_got_q;
                wready  = !w_got_q;
                if (awvalid && !aw_got_q) begin
                    aw_got_d  = 1'b1;
                    aw_addr_d = awaddr;
                end
                if (wvalid && !w_got_q) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    if (txn_delay == 4'd0) begin
                        wr_commit  = 1'b1;
                        wr_state_d = W_BRESP;
                    end else begin
                        wr_cnt_d   = txn_delay - 4'd1;
                        wr_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == 4'd0) begin
                    wr_commit  = 1'b1;
                    wr_state_d = W_BRESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - 4'd1;
                end
            end
            W_BRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase

        if (wr_commit) begin
            bresp_d = addr_in_range(aw_addr_d) ? c_okay : c_slverr;
        end
    end

    // Commit operands come from the _d side so the zero-delay path can use
    // beats accepted on the same edge; elsewhere _d equals _q.
    always_comb begin
        mem_we   = wr_commit && addr_in_range(aw_addr_d);
        mem_idx  = word_index(aw_addr_d);
        mem_data = wdata_d;
        mem_strb = wstrb_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            aw_addr_q  <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            wr_cnt_q   <= 4'd0;
            bresp_q    <= c_okay;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            aw_addr_q  <= aw_addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_cnt_q   <= wr_cnt_d;
            bresp_q    <= bresp_d;
        end
    end

    assign bresp = bresp_q;

endmodule
`default_nettype wire
